// File: rtl/trace_checker_pkg.sv
// Shared types and default sizing for the on-chip trace checker.
//   state_t  : checker FSM states (IDLE, RUN, DONE)
//   entry_t  : one expectation-table entry {cycle, mask, value} at default widths
package trace_checker_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int NUM_SIG_DEF = 4;
  localparam int DEPTH_DEF   = 16;
  localparam int CYC_W_DEF   = 16;
  localparam int ERR_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [CYC_W_DEF-1:0]              cycle;
    logic [NUM_SIG_DEF-1:0]            mask;
    logic [NUM_SIG_DEF*DATA_W_DEF-1:0] value;
  } entry_t;

endpackage

// File: rtl/trace_lane_cmp.sv
// Per-lane masked compare of observed outputs against expected values.
//   obs      : observed lanes, lane 0 in LSBs
//   value    : expected lanes, lane 0 in LSBs
//   mask     : 1 = compare this lane
//   mismatch : 1 per lane that is compared and differs
module trace_lane_cmp #(
  parameter int DATA_W  = 8,
  parameter int NUM_SIG = 4
) (
  input  logic [NUM_SIG*DATA_W-1:0] obs,
  input  logic [NUM_SIG*DATA_W-1:0] value,
  input  logic [NUM_SIG-1:0]        mask,
  output logic [NUM_SIG-1:0]        mismatch
);

  always_comb begin
    mismatch = '0;
    for (int i = 0; i < NUM_SIG; i++) begin
      mismatch[i] = mask[i] && (obs[i*DATA_W +: DATA_W] != value[i*DATA_W +: DATA_W]);
    end
  end

endmodule

// File: rtl/trace_checker.sv
// On-chip response checker. Holds a table of (cycle, mask, value) entries,
// counts clocks after start and compares the observed outputs at each
// scheduled cycle, reporting an error count, the first failing entry and
// pass/fail.
//   clk, rst                 : clock, asynchronous active-high reset
//   prog_en/idx/cycle/mask/value : table write port (ignored in RUN and when start is high)
//   num_entries, start       : entries to check (sampled on start), start pulse
//   obs                      : observed DUT outputs, lane 0 in LSBs
//   busy, done, pass         : status (done/pass sticky until next start or reset)
//   err_count, first_err     : saturating error count, index of first failing entry
//   cycle_cnt                : current check cycle
//   state                    : FSM state for observation
module trace_checker
  import trace_checker_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_SIG = NUM_SIG_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int CYC_W   = CYC_W_DEF,
  parameter int ERR_W   = ERR_W_DEF,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prog_en,
  input  logic [IDX_W-1:0]          prog_idx,
  input  logic [CYC_W-1:0]          prog_cycle,
  input  logic [NUM_SIG-1:0]        prog_mask,
  input  logic [NUM_SIG*DATA_W-1:0] prog_value,
  input  logic [IDX_W:0]            num_entries,
  input  logic                      start,
  input  logic [NUM_SIG*DATA_W-1:0] obs,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ERR_W-1:0]          err_count,
  output logic [IDX_W-1:0]          first_err,
  output logic [CYC_W-1:0]          cycle_cnt,
  output state_t                    state
);

  localparam int ADD_W = $clog2(NUM_SIG + 1);
  localparam int SUM_W = ERR_W + ADD_W;
  localparam logic [CYC_W-1:0] CYC_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [IDX_W:0]   ONE_N   = 1;

  typedef struct packed {
    logic [CYC_W-1:0]          cycle;
    logic [NUM_SIG-1:0]        mask;
    logic [NUM_SIG*DATA_W-1:0] value;
  } slot_t;

  slot_t            table_q [DEPTH];
  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W:0]   num_q;
  logic [CYC_W-1:0] cycle_q;
  logic             sat_q;     // cycle counter has tried to pass CYC_MAX
  logic [ERR_W-1:0] err_q;
  logic [IDX_W-1:0] first_q;
  logic             done_q, pass_q, busy_q;

  slot_t            cur;
  logic [NUM_SIG-1:0] mismatch;
  logic             hit, miss, consume, last;
  logic [ADD_W-1:0] add;
  logic [SUM_W-1:0] sum;
  logic [ERR_W-1:0] err_d;

  assign cur = table_q[ptr_q];

  trace_lane_cmp #(.DATA_W(DATA_W), .NUM_SIG(NUM_SIG)) u_cmp (
    .obs      (obs),
    .value    (cur.value),
    .mask     (cur.mask),
    .mismatch (mismatch)
  );

  // Entry scheduling: an entry whose cycle has already gone by (or any entry
  // left once the counter is pinned at its maximum) is a missed entry.
  always_comb begin
    hit     = !sat_q && (cur.cycle == cycle_q);
    miss    = sat_q || (cur.cycle < cycle_q);
    consume = (state_q == RUN) && (hit || miss);
    last    = ({1'b0, ptr_q} == (num_q - ONE_N));
    add     = '0;
    if (hit) begin
      for (int i = 0; i < NUM_SIG; i++) begin
        add = add + ADD_W'(mismatch[i]);
      end
    end else if (miss) begin
      add = ADD_W'(1);
    end
    sum   = SUM_W'(err_q) + SUM_W'(add);
    err_d = (sum > SUM_W'(ERR_MAX)) ? ERR_MAX : sum[ERR_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = (num_entries == '0) ? DONE : RUN;
      RUN:        if (consume && last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Table is not reset; a write coinciding with start is dropped.
  always_ff @(posedge clk) begin
    if (prog_en && !start && state_q != RUN) begin
      table_q[prog_idx] <= {prog_cycle, prog_mask, prog_value};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      num_q   <= '0;
      cycle_q <= '0;
      sat_q   <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (state_q == RUN) begin
      if (cycle_q == CYC_MAX) sat_q   <= 1'b1;
      else                    cycle_q <= cycle_q + 1'b1;
      if (consume) begin
        err_q <= err_d;
        if (err_q == '0 && err_d != '0) first_q <= ptr_q;
        ptr_q <= ptr_q + 1'b1;
        if (last) begin
          done_q <= 1'b1;
          pass_q <= (err_d == '0);
          busy_q <= 1'b0;
        end
      end
    end else if (start) begin
      ptr_q   <= '0;
      num_q   <= num_entries;
      cycle_q <= '0;
      sat_q   <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      done_q  <= (num_entries == '0);
      pass_q  <= (num_entries == '0);
      busy_q  <= (num_entries != '0);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign first_err = first_q;
  assign cycle_cnt = cycle_q;
  assign state     = state_q;

endmodule

// File: tb/tb_trace_checker.sv
// Directed bench for trace_checker. A second instance with a 2-bit error
// counter shares all inputs to exercise error-count saturation.
module tb_trace_checker;
  import trace_checker_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_en = 1'b0;
  logic [3:0]  prog_idx = '0;
  logic [15:0] prog_cycle = '0;
  logic [3:0]  prog_mask = '0;
  logic [31:0] prog_value = '0;
  logic [4:0]  num_entries = '0;
  logic        start = 1'b0;
  logic [31:0] obs = '0;

  logic        busy, done, pass;
  logic [7:0]  err_count;
  logic [3:0]  first_err;
  logic [15:0] cycle_cnt;
  state_t      state;

  logic        s_busy, s_done, s_pass;
  logic [1:0]  s_err_count;
  logic [3:0]  s_first_err;
  logic [15:0] s_cycle_cnt;
  state_t      s_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] obs_tbl [64];

  always #5 clk = ~clk;

  trace_checker dut (
    .clk(clk), .rst(rst), .prog_en(prog_en), .prog_idx(prog_idx),
    .prog_cycle(prog_cycle), .prog_mask(prog_mask), .prog_value(prog_value),
    .num_entries(num_entries), .start(start), .obs(obs),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err(first_err), .cycle_cnt(cycle_cnt), .state(state)
  );

  trace_checker #(.ERR_W(2)) dut_small (
    .clk(clk), .rst(rst), .prog_en(prog_en), .prog_idx(prog_idx),
    .prog_cycle(prog_cycle), .prog_mask(prog_mask), .prog_value(prog_value),
    .num_entries(num_entries), .start(start), .obs(obs),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err_count),
    .first_err(s_first_err), .cycle_cnt(s_cycle_cnt), .state(s_state)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 64; i++) obs_tbl[i] = '0;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic prog(input int idx, input int cyc, input logic [3:0] m, input logic [31:0] v);
    prog_en    = 1'b1;
    prog_idx   = idx[3:0];
    prog_cycle = cyc[15:0];
    prog_mask  = m;
    prog_value = v;
    @(negedge clk);
    prog_en = 1'b0;
  endtask

  // Pulse start, then present obs_tbl[k] ahead of the edge where cycle_cnt==k.
  // with_prog drives table writes alongside start and mid-run (both must be dropped).
  // abort_at >= 0 asserts reset before the edge that would end cycle abort_at.
  task automatic do_run(input int num, input int bound, input bit with_prog, input int abort_at);
    int k;
    num_entries = num[4:0];
    start = 1'b1;
    if (with_prog) begin
      prog_en = 1'b1; prog_idx = 4'd0; prog_cycle = 16'd0;
      prog_mask = 4'hf; prog_value = 32'h77777777;
    end
    @(negedge clk);
    start = 1'b0;
    prog_en = 1'b0;
    k = 0;
    while (!done && k < bound) begin
      obs = obs_tbl[k];
      if (k == 0) check_val("busy_in_run", {31'd0, busy}, 32'd1);
      if (with_prog && k == 1) begin
        prog_en = 1'b1; prog_idx = 4'd0; prog_cycle = 16'd3;
        prog_mask = 4'hf; prog_value = 32'h99999999;
      end else begin
        prog_en = 1'b0;
      end
      if (k == abort_at) begin
        check_val("cycle_before_abort", {16'd0, cycle_cnt}, abort_at);
        rst = 1'b1;
        #1;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_done", {31'd0, done}, 32'd0);
        check_val("abort_pass", {31'd0, pass}, 32'd0);
        check_val("abort_err", {24'd0, err_count}, 32'd0);
        check_val("abort_cycle", {16'd0, cycle_cnt}, 32'd0);
        check_val("abort_state", 32'(state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      k++;
    end
    prog_en = 1'b0;
    check_val("run_done", {31'd0, done}, 32'd1);
    check_val("run_busy_clear", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_obs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_pass", {31'd0, pass}, 32'd0);
    check_val("rst_err", {24'd0, err_count}, 32'd0);
    check_val("rst_first", {28'd0, first_err}, 32'd0);
    check_val("rst_cycle", {16'd0, cycle_cnt}, 32'd0);
    check_val("rst_state", 32'(state), 32'(IDLE));

    // 1: single lane-a check at cycle 19
    prog(0, 19, 4'b0001, 32'h00000010);
    clear_obs(); obs_tbl[19] = 32'h00000010;
    do_run(1, 40, 1'b0, -1);
    check_val("t1_pass", {31'd0, pass}, 32'd1);
    check_val("t1_err", {24'd0, err_count}, 32'd0);
    check_val("t1_cycle", {16'd0, cycle_cnt}, 32'd20);
    check_val("t1_state", 32'(state), 32'(DONE));

    // 2: second entry sees c=0 where 1 expected
    prog(0, 19, 4'b1111, 32'h00000010);
    prog(1, 20, 4'b0100, 32'h00010000);
    clear_obs(); obs_tbl[19] = 32'h00000010;
    do_run(2, 40, 1'b0, -1);
    check_val("t2_err", {24'd0, err_count}, 32'd1);
    check_val("t2_first", {28'd0, first_err}, 32'd1);
    check_val("t2_pass", {31'd0, pass}, 32'd0);

    // 3a: all four lanes wrong
    prog(0, 2, 4'b1111, 32'h55555555);
    clear_obs();
    do_run(1, 40, 1'b0, -1);
    check_val("t3_err4", {24'd0, err_count}, 32'd4);
    check_val("t3_first", {28'd0, first_err}, 32'd0);
    check_val("t3_small_sat", {30'd0, s_err_count}, 32'd3);
    check_val("t3_small_pass", {31'd0, s_pass}, 32'd0);
    // 3b: five bad lanes in total
    prog(1, 3, 4'b0001, 32'h00000011);
    do_run(2, 40, 1'b0, -1);
    check_val("t3_err5", {24'd0, err_count}, 32'd5);
    check_val("t3_small_sat5", {30'd0, s_err_count}, 32'd3);

    // 4: duplicate cycle -> second entry missed
    prog(0, 5, 4'b0001, 32'h0);
    prog(1, 5, 4'b0001, 32'h0);
    clear_obs();
    do_run(2, 40, 1'b0, -1);
    check_val("t4_err", {24'd0, err_count}, 32'd1);
    check_val("t4_first", {28'd0, first_err}, 32'd1);
    check_val("t4_cycle", {16'd0, cycle_cnt}, 32'd7);

    // 5a: empty table
    do_run(0, 40, 1'b0, -1);
    check_val("t5_pass", {31'd0, pass}, 32'd1);
    check_val("t5_err", {24'd0, err_count}, 32'd0);
    check_val("t5_state", 32'(state), 32'(DONE));
    // 5b: writes with start and during RUN are dropped
    prog(0, 3, 4'b0001, 32'h00000022);
    clear_obs(); obs_tbl[3] = 32'h00000022;
    do_run(1, 40, 1'b1, -1);
    check_val("t5_prog_pass", {31'd0, pass}, 32'd1);
    check_val("t5_prog_err", {24'd0, err_count}, 32'd0);

    // 6: reset at cycle 7, then a clean rerun
    prog(0, 10, 4'b0001, 32'h0);
    clear_obs();
    do_run(1, 40, 1'b0, 7);
    do_run(1, 40, 1'b0, -1);
    check_val("t6_pass", {31'd0, pass}, 32'd1);
    check_val("t6_cycle", {16'd0, cycle_cnt}, 32'd11);

    // 7: full table of DEPTH entries, cycles 0..15
    clear_obs();
    for (int i = 0; i < 16; i++) begin
      prog(i, i, 4'b0001, 32'(i * 3));
      obs_tbl[i] = 32'(i * 3);
    end
    do_run(16, 40, 1'b0, -1);
    check_val("t7_pass", {31'd0, pass}, 32'd1);
    check_val("t7_cycle", {16'd0, cycle_cnt}, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
